// File: rtl/aes_invsubbytes_iter.sv
// Iterative AES inverse SubBytes stage. Substitutes LANES bytes of the 128-bit
// column-major state per cycle (MSB byte first) and presents the result on a
// valid/ready output. One transaction in flight at a time; all outputs are registered.
module aes_invsubbytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int unsigned N  = 16 / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_invsubbytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 inverse S-box, indexed by the input byte.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          st_q;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    work_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];
  logic [127:0]    work_sub;

  // Select the LANES bytes addressed by the pass counter; byte 0 sits at [127:120].
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = 8'h00;
    end
    for (int p = 0; p < N; p++) begin
      for (int l = 0; l < LANES; l++) begin
        if (cnt_q == CW'(p)) begin
          lane_in[l] = work_q[8*(15-(p*LANES+l)) +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_out[g] = INV_SBOX[lane_in[g]];
  end

  // Merge the substituted lanes back into their byte positions.
  always_comb begin
    work_sub = work_q;
    for (int p = 0; p < N; p++) begin
      for (int l = 0; l < LANES; l++) begin
        if (cnt_q == CW'(p)) begin
          work_sub[8*(15-(p*LANES+l)) +: 8] = lane_out[l];
        end
      end
    end
  end

  // Control FSM, pass counter, work register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (in_valid) begin
            work_q     <= state_in;
            cnt_q      <= '0;
            st_q       <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          work_q <= work_sub;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            st_q        <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          // New input is not taken here even if in_valid is high; IDLE takes it next cycle.
          if (out_ready) begin
            st_q        <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          st_q        <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = work_q;

endmodule

// File: tb/tb_aes_invsubbytes_iter.sv
// Testbench for aes_invsubbytes_iter: five instances (LANES = 4, 1, 2, 8, 16) share
// stimulus; directed vectors plus an S-box model derived from GF(2^8) arithmetic.
module tb_aes_invsubbytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] state_in;
  logic [4:0]   in_ready_w;
  logic [4:0]   out_valid_w;
  logic [4:0]   busy_w;
  logic [127:0] so [5];

  int vectors = 0;
  int errors  = 0;
  int npass [5];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  aes_invsubbytes_iter #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .state_in(state_in),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .state_out(so[0]), .busy(busy_w[0]));
  aes_invsubbytes_iter #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .state_in(state_in),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .state_out(so[1]), .busy(busy_w[1]));
  aes_invsubbytes_iter #(.LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]), .state_in(state_in),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .state_out(so[2]), .busy(busy_w[2]));
  aes_invsubbytes_iter #(.LANES(8)) u_l8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[3]), .state_in(state_in),
    .out_valid(out_valid_w[3]), .out_ready(out_ready), .state_out(so[3]), .busy(busy_w[3]));
  aes_invsubbytes_iter #(.LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[4]), .state_in(state_in),
    .out_valid(out_valid_w[4]), .out_ready(out_ready), .state_out(so[4]), .busy(busy_w[4]));

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    logic [15:0] t = {v, v};
    return t[15-n -: 8];
  endfunction

  // Forward S-box = affine(GF inverse); the inverse table is its inversion.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] aff;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      aff = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tab[aff] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = inv_tab[s[8*b +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int pulses = 0;
    state_in = '0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0 || busy_w[i] !== 1'b0 ||
          so[i] !== 128'h0) begin
        errors++;
        $display("FAIL reset_init inst%0d: rdy=%b vld=%b busy=%b out=%h, want 1 0 0 0",
                 i, in_ready_w[i], out_valid_w[i], busy_w[i], so[i]);
      end
    end
    state_in = {16{8'h63}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0 || busy_w[i] !== 1'b0 ||
          so[i] !== 128'h0) begin
        errors++;
        $display("FAIL reset_midrun inst%0d: rdy=%b vld=%b busy=%b out=%h, want 1 0 0 0",
                 i, in_ready_w[i], out_valid_w[i], busy_w[i], so[i]);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (out_valid_w != 5'b0) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_result: %0d out_valid cycles, want 0", pulses);
    end
  endtask

  task automatic test_known_vectors();
    logic [127:0] vin  [4];
    logic [127:0] vexp [4];
    vin[0] = 128'h000102030405060708090a0b0c0d0e0f;
    vexp[0] = 128'h52096ad53036a538bf40a39e81f3d7fb;
    vin[1] = {16{8'h63}}; vexp[1] = {16{8'h00}};
    vin[2] = {16{8'h16}}; vexp[2] = {16{8'hff}};
    vin[3] = {16{8'hed}}; vexp[3] = {16{8'h53}};
    for (int v = 0; v < 4; v++) begin
      int first [5];
      logic [127:0] got [5];
      logic ir1 = 1'bx, ir6 = 1'bx, ir7 = 1'bx;
      for (int i = 0; i < 5; i++) begin
        first[i] = -1;
        got[i] = '0;
      end
      out_ready = 1'b1;
      for (int cyc = 0; cyc <= 20; cyc++) begin
        for (int i = 0; i < 5; i++) begin
          if (out_valid_w[i] && first[i] < 0) begin
            first[i] = cyc;
            got[i] = so[i];
          end
        end
        if (cyc == 1) ir1 = in_ready_w[0];
        if (cyc == 6) ir6 = in_ready_w[0];
        if (cyc == 7) ir7 = in_ready_w[0];
        in_valid = (cyc == 0);
        state_in = (cyc == 0) ? vin[v] : ~vin[v];
        tick();
      end
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (first[i] != npass[i] + 1) begin
          errors++;
          $display("FAIL latency vec%0d inst%0d: first valid cycle %0d, want %0d",
                   v, i, first[i], npass[i] + 1);
        end
        vectors++;
        if (got[i] !== vexp[v]) begin
          errors++;
          $display("FAIL data vec%0d inst%0d: got %h want %h", v, i, got[i], vexp[v]);
        end
      end
      vectors++;
      if (ir1 !== 1'b0 || ir6 !== 1'b1 || ir7 !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_timing vec%0d: c1=%b c6=%b c7=%b, want 0 1 1", v, ir1, ir6, ir7);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] vec  = 128'hdeadbeef_0123_4567_89ab_cdef_f00d_cafe;
    logic [127:0] vec2 = 128'h1122_3344_5566_7788_99aa_bbcc_ddee_ff00;
    int wait_c = 0;
    int cnt = 0;
    logic [127:0] got2 = '0;
    do_reset();
    state_in = vec;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid_w[0] && wait_c < 10) begin
      tick();
      wait_c++;
    end
    vectors++;
    if (!out_valid_w[0]) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b after %0d cycles, want 1", out_valid_w[0], wait_c);
    end
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if (so[0] !== model(vec) || out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c%0d: out=%h vld=%b rdy=%b, want %h 1 0",
                 k, so[0], out_valid_w[0], in_ready_w[0], model(vec));
      end
      in_valid = k[0];
      state_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    // Release with a new input offered in the same DONE cycle.
    in_valid = 1'b1;
    state_in = vec2;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b busy=%b, want 0 1 0",
               out_valid_w[0], in_ready_w[0], busy_w[0]);
    end
    tick();
    in_valid = 1'b0;
    state_in = '0;
    vectors++;
    if (in_ready_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: rdy=%b busy=%b, want 0 1", in_ready_w[0], busy_w[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid_w[0]) begin
        if (cnt == 0) got2 = so[0];
        cnt++;
      end
      tick();
    end
    vectors++;
    if (cnt != 1 || got2 !== model(vec2)) begin
      errors++;
      $display("FAIL bp_second: %0d transfers data %h, want 1 transfer %h",
               cnt, got2, model(vec2));
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vecs [8];
    int sent = 0, got = 0, cyc = 0, last_acc = 0;
    for (int i = 0; i < 8; i++) vecs[i] = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    while (got < 8 && cyc < 500) begin
      in_valid = (sent < 8);
      state_in = (sent < 8) ? vecs[sent] : '0;
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready_w[0] && in_valid) begin
        if (sent > 0) begin
          vectors++;
          if (cyc - last_acc < 6) begin
            errors++;
            $display("FAIL b2b_spacing: %0d cycles between accepts, want >= 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        sent++;
      end
      if (out_valid_w[0] && out_ready) begin
        vectors++;
        if (got >= sent || so[0] !== model(vecs[got])) begin
          errors++;
          $display("FAIL b2b_data #%0d: got %h want %h", got, so[0], model(vecs[got]));
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 8) begin
      errors++;
      $display("FAIL b2b_count: %0d results, want 8", got);
    end
  endtask

  task automatic test_reset_injection();
    for (int t = 0; t < 1000; t++) begin
      logic [127:0] data = {$urandom, $urandom, $urandom, $urandom};
      int rst_at = $urandom_range(1, 10);
      logic rs = 1'b0;
      logic done = 1'b0;
      vectors++;
      if (in_ready_w[0] !== 1'b1) begin
        errors++;
        $display("FAIL inj_idle t%0d: in_ready=%b, want 1", t, in_ready_w[0]);
      end
      in_valid = 1'b1;
      state_in = data;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 11 && !done; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        rst = (c == rst_at);
        if (out_valid_w[0]) begin
          vectors++;
          if (rs || so[0] !== model(data)) begin
            errors++;
            $display("FAIL inj_result t%0d c%0d: after_rst=%b out=%h, want %h and no reset",
                     t, c, rs, so[0], model(data));
          end
          if (out_ready && !rst) done = 1'b1;
        end
        tick();
        if (rst) rs = 1'b1;
        rst = 1'b0;
      end
      do_reset();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    npass[0] = 4; npass[1] = 16; npass[2] = 8; npass[3] = 2; npass[4] = 1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    state_in = '0;
    build_tables();
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_injection();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
